// File: rtl/bld_type_stats_if.sv
// Allele-pair input stream and phenotype output stream for bld_type_stats.
// The master drives pairs and consumes results; the slave is the classifier.
interface bld_type_stats_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] allelm;
    logic [1:0] allelf;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] pheno;

    modport master (
        output in_valid,
        output allelm,
        output allelf,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  pheno
    );

    modport slave (
        input  in_valid,
        input  allelm,
        input  allelf,
        input  out_ready,
        output in_ready,
        output out_valid,
        output pheno
    );
endinterface

// File: rtl/bld_type_stats.sv
// Streaming ABO phenotype classifier: one-deep registered output stage plus
// saturating per-class tallies, a total-accepted count and a sticky sat flag.
module bld_type_stats #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TOT_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    bld_type_stats_if.slave    bus,
    output logic [CNT_W-1:0]   cnt_a,
    output logic [CNT_W-1:0]   cnt_b,
    output logic [CNT_W-1:0]   cnt_ab,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [CNT_W-1:0]   cnt_ill,
    output logic [TOT_W-1:0]   cnt_tot,
    output logic               sat
);

    localparam int unsigned NumCls = 5;
    localparam logic [2:0]  PhIll  = 3'd7;
    localparam logic [2:0]  ClsIll = 3'd4;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [TOT_W-1:0] TotMax = '1;
    localparam logic [TOT_W-1:0] TotOne = TOT_W'(1);

    logic             out_valid_q;
    logic [2:0]       pheno_q;
    logic             accept;
    logic [2:0]       dec;
    logic [2:0]       cls;

    logic [CNT_W-1:0] cls_q [NumCls];
    logic [CNT_W-1:0] cls_d [NumCls];
    logic [TOT_W-1:0] tot_q;
    logic [TOT_W-1:0] tot_d;
    logic             sat_q;
    logic             sat_d;

    // Only out_ready reaches in_ready combinationally.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.pheno     = pheno_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Full decode table indexed by {maternal, paternal}.
    always_comb begin
        dec = PhIll;
        case ({bus.allelm, bus.allelf})
            4'b0000, 4'b0010, 4'b1000: dec = 3'd0;
            4'b0101, 4'b0110, 4'b1001: dec = 3'd1;
            4'b0001, 4'b0100:          dec = 3'd2;
            4'b1010:                   dec = 3'd3;
            default:                   dec = PhIll;
        endcase
    end

    assign cls = (dec == PhIll) ? ClsIll : dec;

    // clr zeroes the base first so a same-cycle accept is counted on top of it.
    always_comb begin
        sat_d = clr ? 1'b0 : sat_q;
        tot_d = clr ? '0 : tot_q;
        for (int i = 0; i < NumCls; i++) begin
            cls_d[i] = clr ? '0 : cls_q[i];
        end
        if (accept) begin
            for (int i = 0; i < NumCls; i++) begin
                if (cls == 3'(i)) begin
                    if (cls_d[i] == CntMax) begin
                        sat_d = 1'b1;
                    end else begin
                        cls_d[i] = cls_d[i] + CntOne;
                    end
                end
            end
            if (tot_d == TotMax) begin
                sat_d = 1'b1;
            end else begin
                tot_d = tot_d + TotOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pheno_q     <= 3'd0;
            tot_q       <= '0;
            sat_q       <= 1'b0;
            for (int i = 0; i < NumCls; i++) begin
                cls_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                pheno_q     <= dec;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            tot_q <= tot_d;
            sat_q <= sat_d;
            for (int i = 0; i < NumCls; i++) begin
                cls_q[i] <= cls_d[i];
            end
        end
    end

    assign cnt_a   = cls_q[0];
    assign cnt_b   = cls_q[1];
    assign cnt_ab  = cls_q[2];
    assign cnt_o   = cls_q[3];
    assign cnt_ill = cls_q[4];
    assign cnt_tot = tot_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_bld_type_stats.sv
// Bench for bld_type_stats: decode table, backpressure, saturation, clr/rst
// corner cases and a randomized valid/ready run against a scoreboard model.
module tb_bld_type_stats;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic clr0;
    logic clr1;

    bld_type_stats_if bus0 ();
    bld_type_stats_if bus1 ();

    logic [7:0] a0, b0, ab0, o0, ill0;
    logic [9:0] tot0;
    logic       sat0;
    logic [1:0] a1, b1, ab1, o1, ill1;
    logic [9:0] tot1;
    logic       sat1;

    bld_type_stats #(.CNT_W(8), .TOT_W(10)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr0),
        .bus     (bus0),
        .cnt_a   (a0),
        .cnt_b   (b0),
        .cnt_ab  (ab0),
        .cnt_o   (o0),
        .cnt_ill (ill0),
        .cnt_tot (tot0),
        .sat     (sat0)
    );

    bld_type_stats #(.CNT_W(2), .TOT_W(10)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr1),
        .bus     (bus1),
        .cnt_a   (a1),
        .cnt_b   (b1),
        .cnt_ab  (ab1),
        .cnt_o   (o1),
        .cnt_ill (ill1),
        .cnt_tot (tot1),
        .sat     (sat1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Phenotype from antigen presence: O carries no antigen.
    function automatic int ref_pheno(input int m, input int f);
        bit has_a;
        bit has_b;
        if (m == 3 || f == 3) return 7;
        has_a = (m == 0) || (f == 0);
        has_b = (m == 1) || (f == 1);
        if (has_a && has_b) return 2;
        if (has_a) return 0;
        if (has_b) return 1;
        return 3;
    endfunction

    typedef struct {
        logic [1:0] m;
        logic [1:0] f;
        logic [2:0] exp;
    } vec_t;

    vec_t vt [16];

    int     q [$];
    int     m_cls [5];
    int     m_tot;
    bit     m_sat;
    bit     pend;
    bit     exp_ready;
    bit     acc;
    int     pm;
    int     pf;
    int     p;
    int     k;

    initial begin
        vt[0]  = '{2'd0, 2'd0, 3'd0};  vt[1]  = '{2'd0, 2'd1, 3'd2};
        vt[2]  = '{2'd0, 2'd2, 3'd0};  vt[3]  = '{2'd0, 2'd3, 3'd7};
        vt[4]  = '{2'd1, 2'd0, 3'd2};  vt[5]  = '{2'd1, 2'd1, 3'd1};
        vt[6]  = '{2'd1, 2'd2, 3'd1};  vt[7]  = '{2'd1, 2'd3, 3'd7};
        vt[8]  = '{2'd2, 2'd0, 3'd0};  vt[9]  = '{2'd2, 2'd1, 3'd1};
        vt[10] = '{2'd2, 2'd2, 3'd3};  vt[11] = '{2'd2, 2'd3, 3'd7};
        vt[12] = '{2'd3, 2'd0, 3'd7};  vt[13] = '{2'd3, 2'd1, 3'd7};
        vt[14] = '{2'd3, 2'd2, 3'd7};  vt[15] = '{2'd3, 2'd3, 3'd7};

        rst = 1'b1;
        clr0 = 1'b0;
        clr1 = 1'b0;
        bus0.in_valid = 1'b0; bus0.allelm = 2'd0; bus0.allelf = 2'd0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.allelm = 2'd0; bus1.allelf = 2'd0; bus1.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_pheno", bus0.pheno, 0);
        chk("rst_in_ready", bus0.in_ready, 1);
        chk("rst_cnt_tot", tot0, 0);
        chk("rst_cnt_ill", ill0, 0);
        chk("rst_sat", sat0, 0);

        // All 16 combinations back-to-back
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus0.in_valid = 1'b1;
            bus0.allelm   = vt[i].m;
            bus0.allelf   = vt[i].f;
            tick();
            chk($sformatf("tbl_pheno_%0d", i), bus0.pheno, vt[i].exp);
            chk($sformatf("tbl_valid_%0d", i), bus0.out_valid, 1);
        end
        bus0.in_valid = 1'b0;
        chk("tbl_cnt_a", a0, 3);
        chk("tbl_cnt_b", b0, 3);
        chk("tbl_cnt_ab", ab0, 2);
        chk("tbl_cnt_o", o0, 1);
        chk("tbl_cnt_ill", ill0, 7);
        chk("tbl_cnt_tot", tot0, 16);
        chk("tbl_sat", sat0, 0);
        tick();
        chk("drain_valid", bus0.out_valid, 0);
        chk("drain_pheno_hold", bus0.pheno, 7);

        // Backpressure
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.allelm    = 2'd1;
        bus0.allelf    = 2'd2;
        tick();
        chk("bp_cnt_b_now", b0, 1);
        bus0.allelm = 2'd0;
        bus0.allelf = 2'd0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", bus0.in_ready, 0);
            chk("bp_pheno", bus0.pheno, 1);
            chk("bp_valid", bus0.out_valid, 1);
            tick();
        end
        chk("bp_cnt_b", b0, 1);
        chk("bp_cnt_a", a0, 0);
        bus0.out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", bus0.in_ready, 1);
        tick();
        chk("bp_pheno_new", bus0.pheno, 0);
        chk("bp_cnt_a_new", a0, 1);
        bus0.in_valid = 1'b0;
        tick();

        // Saturation on the narrow instance
        bus1.allelm = 2'd2;
        bus1.allelf = 2'd2;
        bus1.in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("sat_cnt_o_%0d", i), o1, (i > 3) ? 3 : i);
            chk($sformatf("sat_flag_%0d", i), sat1, (i >= 4) ? 1 : 0);
        end
        bus1.in_valid = 1'b0;
        chk("sat_cnt_tot", tot1, 5);

        // clr coinciding with an accept
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.allelm = 2'd0;
        bus0.allelf = 2'd0;
        for (int i = 0; i < 4; i++) tick();
        chk("clr_pre_cnt_a", a0, 4);
        clr0 = 1'b1;
        bus0.allelm = 2'd1;
        bus0.allelf = 2'd1;
        tick();
        clr0 = 1'b0;
        bus0.in_valid = 1'b0;
        chk("clr_cnt_a", a0, 0);
        chk("clr_cnt_b", b0, 1);
        chk("clr_cnt_tot", tot0, 1);
        chk("clr_sat", sat0, 0);
        chk("clr_pheno", bus0.pheno, 1);

        // Reset with an undelivered result
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.allelm = 2'd2;
        bus0.allelf = 2'd2;
        tick();
        chk("mid_valid", bus0.out_valid, 1);
        bus0.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", bus0.out_valid, 0);
        chk("mid_rst_pheno", bus0.pheno, 0);
        chk("mid_rst_cnt_o", o0, 0);
        chk("mid_rst_cnt_tot", tot0, 0);
        chk("mid_rst_in_ready", bus0.in_ready, 1);

        // Randomized valid/ready stress against the scoreboard
        for (int i = 0; i < 5; i++) m_cls[i] = 0;
        m_tot = 0;
        m_sat = 0;
        pend = 0;
        pm = 0;
        pf = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!pend) begin
                pm = $urandom_range(0, 3);
                pf = $urandom_range(0, 3);
                bus0.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus0.allelm = pm[1:0];
            bus0.allelf = pf[1:0];
            pend = bus0.in_valid;
            bus0.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = (q.size() == 0) || bus0.out_ready;
            chk("rnd_in_ready", bus0.in_ready, exp_ready);
            chk("rnd_out_valid", bus0.out_valid, q.size() != 0);
            if (q.size() != 0) chk("rnd_pheno", bus0.pheno, q[0]);
            acc = bus0.in_valid && exp_ready;
            if (q.size() != 0 && bus0.out_ready) void'(q.pop_front());
            if (acc) begin
                p = ref_pheno(pm, pf);
                q.push_back(p);
                k = (p == 7) ? 4 : p;
                if (m_cls[k] == 255) m_sat = 1; else m_cls[k]++;
                if (m_tot == 1023) m_sat = 1; else m_tot++;
                pend = 0;
            end
            tick();
            chk("rnd_cnt_a", a0, m_cls[0]);
            chk("rnd_cnt_b", b0, m_cls[1]);
            chk("rnd_cnt_ab", ab0, m_cls[2]);
            chk("rnd_cnt_o", o0, m_cls[3]);
            chk("rnd_cnt_ill", ill0, m_cls[4]);
            chk("rnd_cnt_tot", tot0, m_tot);
            chk("rnd_sat", sat0, m_sat);
            if (!m_sat) begin
                chk("rnd_sum", 32'(a0) + 32'(b0) + 32'(ab0) + 32'(o0) + 32'(ill0), 32'(tot0));
            end
        end
        bus0.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bld_type_stats.md
# bld_type_stats

Streaming ABO phenotype classifier with per-phenotype tally counters. It accepts one maternal/paternal allele pair per accepted transfer over a valid/ready handshake and emits the decoded phenotype through a one-deep registered output stage with backpressure. It keeps saturating counts of every phenotype class and of illegal entries. It sits between the sample-entry front end and the report/display logic, and supersedes the purely combinational single-pair decoder.

## Interface
- CNT_W, 8: width of each tally counter. Legal range is 2..32.
- TOT_W, 10: width of the total-accepted counter. Must be ≥ CNT_W.

- clk  in  1  sole clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of all counters and sat flags. Does not touch the output stage.
- in_valid  in  1  an allele pair is offered.
- in_ready  out  1  the block can accept a pair this cycle.
- allelm  in  2  maternal allele: 00=A, 01=B, 10=O, 11=illegal.
- allelf  in  2  paternal allele, same encoding.
- out_valid  out  1  pheno holds an undelivered result.
- out_ready  in  1  the downstream consumer takes the result.
- pheno  out  3  phenotype: 0=A, 1=B, 2=AB, 3=O, 7=illegal.
- cnt_a, cnt_b, cnt_ab, cnt_o, cnt_ill  out  CNT_W each  per-class tallies.
- cnt_tot  out  TOT_W  total accepted pairs.
- sat  out  1  sticky: set when any counter has saturated.

## Operation
- Accept: a pair is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational, so a full pipeline can accept a new pair in the same cycle the old result drains.
- Decode, symmetric in allelm/allelf:
  - {A,A}, {A,O} → A (0).
  - {B,B}, {B,O} → B (1).
  - {A,B} → AB (2).
  - {O,O} → O (3).
  - Any allele equal to 11 → 7.
- Output stage:
  - On accept: pheno is loaded and out_valid is set.
  - On out_ready && out_valid with no accept: out_valid clears and pheno holds its last value.
  - While out_valid && !out_ready: pheno and out_valid hold.
- Counters, on each accept:
  - Increment the class counter (cnt_ill for code 7) and cnt_tot.
  - Each counter saturates at its all-ones value and never wraps.
  - Any increment attempted on a saturated counter sets sat.
- clr:
  - All counters and sat go to 0 next cycle.
  - If an accept happens in the same cycle as clr, clr is applied first and the accepted pair is then counted. Its class counter and cnt_tot read 1; everything else reads 0.
- rst:
  - out_valid=0, pheno=0, all counters 0, sat=0. in_ready therefore reads 1 after reset.
  - rst has priority over clr and accept.
  - An undelivered result is discarded on reset mid-operation.

## Timing
- Latency is 1 cycle: a pair accepted at edge N shows up on pheno/out_valid after edge N.
- Counters reflect the accept after the same edge N.
- Throughput is 1 pair/cycle when out_ready is held high.
- Inputs sampled while in_ready=0 are ignored. The upstream source must hold allelm/allelf stable until accepted.
- pheno is stable while out_valid && !out_ready.
- There is no combinational path from allelm/allelf to any output. The only combinational path is out_ready → in_ready.

## Test plan
- Reset, then drive all 16 allele combinations back-to-back with out_ready=1 → pheno follows the decode table one cycle later; cnt_a=3, cnt_b=3, cnt_ab=2, cnt_o=1, cnt_ill=7, cnt_tot=16, sat=0.
- Backpressure: accept {01,10}, hold out_ready=0 for 3 cycles while offering {00,00} → pheno=1 held, in_ready=0, cnt_b=1, cnt_a=0. Raise out_ready → the {00,00} pair is accepted that same cycle and pheno=0 appears next cycle.
- Saturation with CNT_W=2: accept 5 × {10,10} → cnt_o goes 1,2,3,3,3; sat=1 after the 4th accept; cnt_tot=5.
- clr and accept in the same cycle, after 4 prior A results → cnt_a=0, cnt_b=1 (pair {01,01}), cnt_tot=1, sat=0.
- rst asserted while out_valid=1, out_ready=0 → next cycle out_valid=0, pheno=0, all counters 0, in_ready=1.
- Random valid/ready stress over 10k cycles, checked against a scoreboard → no lost or duplicated results, and counter sums equal cnt_tot until saturation.
